// File: rtl/nn_frame_sequencer_if.sv
// Stream bundle for nn_frame_sequencer.
// Operand stream: s_valid/s_data/s_last (host -> sequencer) and s_ready (sequencer -> host).
// Result stream:  m_valid/m_data/m_last (sequencer -> host) and m_ready (host -> sequencer).
// master = host/DMA side, slave = sequencer side.
interface nn_frame_sequencer_if #(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
);
    logic             s_valid;
    logic [IN_W-1:0]  s_data;
    logic             s_last;
    logic             s_ready;
    logic             m_valid;
    logic [OUT_W-1:0] m_data;
    logic             m_last;
    logic             m_ready;

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/nn_frame_sequencer.sv
// Serial front end for the alu + sigmoid layer datapath.
// Collects N_IN operand words into op_bus, waits SETTLE cycles for the
// combinational layer to resolve, captures res_bus, then streams the N_OUT
// results out one per handshake.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : operand/result streams (slave side of nn_frame_sequencer_if)
//   op_bus     : registered operands to alu, slot k at [k*IN_W +: IN_W]
//   res_bus    : sigmoid outputs, result j at [j*OUT_W +: OUT_W]
//   err_len    : one-cycle pulse on a frame-length error
//   busy       : high whenever the sequencer is not idle in LOAD with idx==0
module nn_frame_sequencer #(
    parameter int unsigned N_IN   = 22,
    parameter int unsigned IN_W   = 16,
    parameter int unsigned N_OUT  = 4,
    parameter int unsigned OUT_W  = 32,
    parameter int unsigned SETTLE = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    nn_frame_sequencer_if.slave    bus,
    output logic [N_IN*IN_W-1:0]   op_bus,
    input  logic [N_OUT*OUT_W-1:0] res_bus,
    output logic                   err_len,
    output logic                   busy
);
    localparam int unsigned IDX_W = (N_IN  > 1) ? $clog2(N_IN)  : 1;
    localparam int unsigned K_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int unsigned CNT_W = 4;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);
    localparam logic [K_W-1:0]   LAST_K   = K_W'(N_OUT - 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [K_W-1:0]   k;
    logic [K_W-1:0]   k_nxt;
    logic [CNT_W-1:0] cnt;
    logic [OUT_W-1:0] result [N_OUT];

    assign k_nxt = k + K_W'(1);

    // Frame sequencer: all outputs are registered and updated with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_LOAD;
            idx         <= '0;
            k           <= '0;
            cnt         <= '0;
            op_bus      <= '0;
            for (int unsigned j = 0; j < N_OUT; j++) begin
                result[j] <= '0;
            end
            bus.s_ready <= 1'b0;
            bus.m_valid <= 1'b0;
            bus.m_data  <= '0;
            bus.m_last  <= 1'b0;
            err_len     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            err_len <= 1'b0;
            case (state)
                ST_LOAD: begin
                    // Also raises s_ready on the first cycle out of reset.
                    bus.s_ready <= 1'b1;
                    if (bus.s_valid && bus.s_ready) begin
                        if (idx == LAST_IDX) begin
                            // Final slot: a missing s_last is flagged but the frame still runs.
                            op_bus[idx*IN_W +: IN_W] <= bus.s_data;
                            idx         <= '0;
                            cnt         <= CNT_INIT;
                            state       <= ST_SETTLE;
                            bus.s_ready <= 1'b0;
                            busy        <= 1'b1;
                            err_len     <= ~bus.s_last;
                        end else if (bus.s_last) begin
                            // Short frame: drop the word and restart at slot 0.
                            idx     <= '0;
                            err_len <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            op_bus[idx*IN_W +: IN_W] <= bus.s_data;
                            idx  <= idx + IDX_W'(1);
                            busy <= 1'b1;
                        end
                    end
                end

                ST_SETTLE: begin
                    if (cnt == '0) begin
                        state <= ST_CAPTURE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end

                ST_CAPTURE: begin
                    for (int unsigned j = 0; j < N_OUT; j++) begin
                        result[j] <= res_bus[j*OUT_W +: OUT_W];
                    end
                    bus.m_data  <= res_bus[OUT_W-1:0];
                    bus.m_valid <= 1'b1;
                    bus.m_last  <= (N_OUT == 1);
                    k           <= '0;
                    state       <= ST_DRAIN;
                end

                ST_DRAIN: begin
                    if (bus.m_ready) begin
                        if (k == LAST_K) begin
                            bus.m_valid <= 1'b0;
                            bus.m_last  <= 1'b0;
                            bus.m_data  <= '0;
                            bus.s_ready <= 1'b1;
                            idx         <= '0;
                            busy        <= 1'b0;
                            state       <= ST_LOAD;
                        end else begin
                            k          <= k_nxt;
                            bus.m_data <= result[k_nxt];
                            bus.m_last <= (k_nxt == LAST_K);
                        end
                    end
                end

                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end
endmodule

// File: doc/nn_frame_sequencer.md
Name: nn_frame_sequencer

Overview:
- Sequential wrapper around the combinational layer datapath, i.e. `alu` followed by four `sigmoid_32bit` instances.
- Accepts a stream of 16-bit operand words over a valid/ready handshake and assembles them into the 22-operand parallel bus that drives `alu`.
- Waits a programmable settle time, then captures the four 32-bit sigmoid results.
- Streams the results out one per handshake, making the layer usable from a serial host or DMA port.

Parameters:
- N_IN, 22, operands per frame (alu inputs in0..in21)
- IN_W, 16, operand width
- N_OUT, 4, results per frame (sigmoid outputs)
- OUT_W, 32, result width
- SETTLE, 2, cycles between last operand accepted and result capture (1..15)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- s_valid  input  1  operand word valid
- s_data  input  IN_W  operand word; first word of a frame maps to in0
- s_last  input  1  marks final word of a frame
- s_ready  output  1  sequencer accepts operand
- op_bus  output  N_IN*IN_W  registered operands to alu; slot k at bits [k*IN_W +: IN_W]
- res_bus  input  N_OUT*OUT_W  sigmoid outputs; result j at bits [j*OUT_W +: OUT_W]
- m_valid  output  1  result word valid
- m_data  output  OUT_W  result word; result 0 first
- m_last  output  1  marks result N_OUT-1
- m_ready  input  1  consumer accepts result
- err_len  output  1  one-cycle pulse on frame-length error
- busy  output  1  high in any state other than LOAD with idx==0

Behaviour:
- Reset (async, rst_n=0) forces the following, with no partial state retained:
  - state=LOAD, idx=0, op_bus=0, result regs=0.
  - s_ready=0 while in reset; m_valid=0, m_last=0, m_data=0, err_len=0, busy=0.
- Handshakes:
  - A transfer occurs when valid&&ready at a clk edge.
  - s_ready depends only on state.
  - m_valid and m_data remain stable until accepted.
- States:
  - LOAD
    - s_ready=1.
    - Each accepted word is written to slot idx, then idx++.
    - If s_last=1 and idx<N_IN-1: word discarded, idx←0, err_len pulses, stay in LOAD (frame aborted).
    - When idx==N_IN-1 is accepted: go to SETTLE, cnt←SETTLE-1. If s_last=0 on that word, err_len pulses but the frame is still processed.
  - SETTLE
    - s_ready=0; op_bus held constant.
    - cnt decrements each cycle; at cnt==0 go to CAPTURE.
  - CAPTURE (1 cycle)
    - Result regs ← res_bus, k←0, go to DRAIN.
    - Total latency from last-operand accept edge to m_valid high = SETTLE+1 cycles.
  - DRAIN
    - m_valid=1, m_data=result[k], m_last=(k==N_OUT-1), s_ready=0.
    - On accept: k++. On accepting k==N_OUT-1: m_valid drops the next cycle, idx←0, go to LOAD.
    - m_ready held low stalls indefinitely with outputs stable.
- op_bus:
  - Retains the previous frame's operands until overwritten slot by slot during the next LOAD.
  - Only captured results are guaranteed coherent.
- Widths: no arithmetic on data; idx is ceil(log2(N_IN)) bits, k is ceil(log2(N_OUT)) bits, cnt is 4 bits.
- s_valid asserted outside LOAD: ignored, no side effects.
- Reset mid-DRAIN or mid-SETTLE: outputs drop asynchronously; the pending frame is lost.

Test Plan:
- Reset then 22 words of 0x0002 (s_last on the 22nd):
  - op_bus = 22 slots of 0x0002.
  - With the bench driving res_bus = {0x44444444,0x33333333,0x22222222,0x11111111}, m_data sequence is 0x11111111,0x22222222,0x33333333,0x44444444 with m_last on the 4th.
  - m_valid rises exactly 3 cycles after the last accept (SETTLE=2).
- Full integration with the real alu+sigmoid chain:
  - Send frame 2 (words 0x0006,0x000A,0x000A,0x0006,…,0x0006).
  - The 4 streamed results must equal the sigmoid outputs computed combinationally from the same operand set.
- Backpressure:
  - m_ready=0 for 10 cycles during DRAIN → m_data/m_valid stable, no result skipped.
  - s_valid toggled randomly during LOAD → slots filled in order, no duplicates.
- Early s_last on the 5th word:
  - err_len pulses one cycle, no results emitted.
  - The following clean 22-word frame processes normally.
- Missing s_last on the 22nd word:
  - err_len pulses, and the frame still yields 4 results.
- Assert rst_n=0 mid-SETTLE and again mid-DRAIN (k=2):
  - All outputs zero immediately, s_ready=1 after release.
  - The next frame's first word lands in slot 0.
